pwm_multich: RTL and testbench

Parametrised multi-channel PWM peripheral that succeeds the single-channel P0 PWM on the LnL SoC I/O bus. It provides CHANNELS outputs that share one prescaler and one period counter, and each channel has its own duty register. Period, duty and mode registers are double-buffered so the CPU can update them glitch-free. It supports edge-aligned and center-aligned modes and raises a period-boundary interrupt pulse for the CPU's interrupt input.

---
 rtl/pwm_multich.sv | 143 ++++++++++++++
 tb/tb_pwm_multich.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_multich.sv
// pwm_multich: CHANNELS PWM outputs on a shared prescaler and period counter.
// Period, duty and mode are double-buffered and reload at each period boundary.
module pwm_multich #(
  parameter int CHANNELS = 4,
  parameter int CW = 8,
  parameter int PSW = 4,
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       addr,
  input  logic [DW-1:0]       wr_data,
  output logic [DW-1:0]       rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_irq
);

  logic           en;
  logic           mode;
  logic           mode_act;
  logic           dir;
  logic           tick;
  logic           bnd;
  logic           unused_wr;
  logic [PSW-1:0] ps;
  logic [PSW-1:0] pcnt;
  logic [CW-1:0]  period;
  logic [CW-1:0]  p_act;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  duty  [CHANNELS];
  logic [CW-1:0]  d_act [CHANNELS];

  assign unused_wr = ^wr_data;

  assign tick = en && (pcnt == ps);

  // Programmed (CPU-visible) registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en     <= 1'b0;
      mode   <= 1'b0;
      ps     <= '0;
      period <= '0;
      for (int i = 0; i < CHANNELS; i++)
        duty[i] <= '0;
    end else if (wr_en) begin
      if (addr == AW'(0)) begin
        en   <= wr_data[0];
        mode <= wr_data[1];
        ps   <= wr_data[PSW+1:2];
      end
      if (addr == AW'(1))
        period <= wr_data[CW-1:0];
      for (int i = 0; i < CHANNELS; i++)
        if (addr == AW'(i + 2))
          duty[i] <= wr_data[CW-1:0];
    end
  end

  // Period boundary: last tick of the current period
  always_comb begin
    bnd = 1'b0;
    if (!mode_act)
      bnd = (cnt == p_act);
    else
      bnd = (p_act == '0) ||
            ((cnt == CW'(1)) && (dir || p_act == CW'(1)));
  end

  // Prescaler and up / up-down period counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
    end else if (!en) begin
      pcnt <= '0;
      cnt  <= '0;
      dir  <= 1'b0;
    end else begin
      pcnt <= (pcnt >= ps) ? '0 : pcnt + 1'b1;
      if (tick) begin
        if (bnd) begin
          cnt <= '0;
          dir <= 1'b0;
        end else if (!mode_act) begin
          cnt <= cnt + 1'b1;
        end else if (!dir && cnt == p_act) begin
          cnt <= cnt - 1'b1;
          dir <= 1'b1;
        end else if (!dir) begin
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Active copies: follow programmed values while idle, reload at boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_act    <= '0;
      mode_act <= 1'b0;
      for (int i = 0; i < CHANNELS; i++)
        d_act[i] <= '0;
    end else if (!en || (tick && bnd)) begin
      p_act    <= period;
      mode_act <= mode;
      for (int i = 0; i < CHANNELS; i++)
        d_act[i] <= duty[i];
    end
  end

  // Registered compare outputs and boundary pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_out    <= '0;
      period_irq <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        pwm_out[i] <= en & (cnt < d_act[i]);
      period_irq <= tick & bnd;
    end
  end

  // Register read mux
  always_comb begin
    rd_data = '0;
    if (addr == AW'(0))
      rd_data = DW'({ps, mode, en});
    if (addr == AW'(1))
      rd_data = DW'(period);
    for (int i = 0; i < CHANNELS; i++)
      if (addr == AW'(i + 2))
        rd_data = DW'(duty[i]);
    if (addr == AW'(CHANNELS + 2))
      rd_data = DW'({dir, cnt});
  end

endmodule

// File: tb/tb_pwm_multich.sv
// tb_pwm_multich: directed and randomized checks of pwm_multich
// against a period-sequence reference model.
module tb_pwm_multich;
  localparam int CH = 4;
  localparam int CW = 8;
  localparam int PSW = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int ST = CH + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [CH-1:0] pwm_out;
  logic          period_irq;

  int checks = 0;
  int errors = 0;

  // Model: programmed values, current period as a per-clock list of (cnt, dir)
  int m_en, m_mode, m_ps, m_p;
  int m_d [CH];
  int dact [CH];
  int sq_cnt [$];
  int sq_dir [$];
  int k;
  logic [CH-1:0] e_pwm;
  logic e_irq;
  bit e_valid;

  pwm_multich #(.CHANNELS(CH), .CW(CW), .PSW(PSW), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .pwm_out(pwm_out), .period_irq(period_irq)
  );

  always #5 clk = ~clk;

  function automatic void load();
    sq_cnt.delete();
    sq_dir.delete();
    for (int v = 0; v <= m_p; v++)
      for (int r = 0; r <= m_ps; r++) begin
        sq_cnt.push_back(v);
        sq_dir.push_back(0);
      end
    if (m_mode != 0)
      for (int v = m_p - 1; v >= 1; v--)
        for (int r = 0; r <= m_ps; r++) begin
          sq_cnt.push_back(v);
          sq_dir.push_back(1);
        end
    for (int c = 0; c < CH; c++) dact[c] = m_d[c];
  endfunction

  function automatic void model_reset();
    m_en = 0; m_mode = 0; m_ps = 0; m_p = 0;
    for (int c = 0; c < CH; c++) m_d[c] = 0;
    load();
    k = 0; e_valid = 0; e_pwm = '0; e_irq = 1'b0;
  endfunction

  function automatic void model_edge(bit w, int a, int d);
    for (int c = 0; c < CH; c++)
      e_pwm[c] = (m_en != 0) && (sq_cnt[k] < dact[c]);
    e_irq = 1'b0;
    if (m_en == 0) begin
      load(); k = 0;
    end else if (k == sq_cnt.size() - 1) begin
      e_irq = 1'b1; load(); k = 0;
    end else begin
      k++;
    end
    e_valid = (m_en != 0);
    if (w) begin
      if (a == 0) begin
        m_en = d & 1; m_mode = (d >> 1) & 1; m_ps = (d >> 2) & ((1 << PSW) - 1);
      end else if (a == 1) begin
        m_p = d & ((1 << CW) - 1);
      end else if (a >= 2 && a < 2 + CH) begin
        m_d[a-2] = d & ((1 << CW) - 1);
      end
    end
  endfunction

  function automatic logic [DW-1:0] exp_status();
    if (!e_valid) return '0;
    return DW'((sq_dir[k] << CW) | sq_cnt[k]);
  endfunction

  task automatic cycle(input bit w, input int a, input int d);
    wr_en = w; addr = AW'(a); wr_data = DW'(d);
    @(posedge clk); #1;
    model_edge(w, a, d);
    wr_en = 1'b0; addr = AW'(ST); wr_data = '0;
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] got;
    rst = 1'b1; wr_en = 1'b0; addr = AW'(ST); wr_data = '0;
    model_reset();
    #1;
    checks++;
    if (pwm_out !== '0 || period_irq !== 1'b0) begin
      errors++; $display("FAIL reset_out pwm=%b irq=%b exp 0", pwm_out, period_irq);
    end
    for (int a = 0; a < 16; a++) begin
      addr = AW'(a); #1; got = rd_data;
      checks++;
      if (got !== '0) begin
        errors++; $display("FAIL reset_rd addr=%0d got %h exp 0", a, got);
      end
    end
    addr = AW'(ST);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {4'b0, 1'b0, 16'h0}) begin
        errors++; $display("FAIL idle t=%0d pwm=%b irq=%b st=%h exp 0", t, pwm_out, period_irq, rd_data);
      end
    end
  endtask

  task automatic test_regs();
    int d;
    logic [DW-1:0] got;
    cycle(1, 0, 16'hfffe);
    addr = AW'(0); #1; got = rd_data;
    checks++;
    if (got !== 16'h003e) begin
      errors++; $display("FAIL rd_ctrl got %h exp 003e", got);
    end
    for (int a = 1; a < 2 + CH; a++) begin
      d = $urandom_range(0, 65535);
      cycle(1, a, d);
      addr = AW'(a); #1; got = rd_data;
      checks++;
      if (got !== DW'(d & 255)) begin
        errors++; $display("FAIL rd_reg addr=%0d got %h exp %h", a, got, d & 255);
      end
    end
    cycle(1, 7, 16'hffff);
    cycle(1, 15, 16'hffff);
    addr = AW'(7); #1; got = rd_data;
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL rd_unused got %h exp 0", got);
    end
    addr = AW'(1); #1; got = rd_data;
    checks++;
    if (got !== DW'(m_p)) begin
      errors++; $display("FAIL rd_period_kept got %h exp %h", got, m_p);
    end
    addr = AW'(ST);
    cycle(1, 0, 0);
  endtask

  task automatic test_edge_basic();
    int win[$]; int ic[$]; int hi;
    hi = 0;
    cycle(1, 0, 0); cycle(1, 1, 9); cycle(1, 2, 3); cycle(1, 0, 1);
    for (int t = 0; t < 45; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL edge_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      hi += int'(pwm_out[0]);
      if (period_irq) begin win.push_back(hi); ic.push_back(t); hi = 0; end
    end
    checks++;
    if (win.size() < 4 || win[1] != 3 || win[2] != 3 || ic[2] - ic[1] != 10) begin
      errors++; $display("FAIL edge_shape n=%0d hi=%0d gap=%0d exp hi=3 gap=10", win.size(), win[1], ic[2] - ic[1]);
    end
  endtask

  task automatic test_duty_extremes();
    cycle(1, 0, 0); cycle(1, 1, 9);
    cycle(1, 2, 5); cycle(1, 3, 0); cycle(1, 4, 10); cycle(1, 5, 255);
    cycle(1, 0, 1);
    for (int t = 0; t < 25; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL ext_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      checks++;
      if (pwm_out[3:1] !== 3'b110) begin
        errors++; $display("FAIL ext_const t=%0d got %b exp 110", t, pwm_out[3:1]);
      end
    end
  endtask

  task automatic test_center();
    int win[$]; int ic[$]; int hi;
    hi = 0;
    cycle(1, 0, 2); cycle(1, 1, 4); cycle(1, 2, 2); cycle(1, 0, 3);
    for (int t = 0; t < 40; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL ctr_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      hi += int'(pwm_out[0]);
      if (period_irq) begin win.push_back(hi); ic.push_back(t); hi = 0; end
    end
    checks++;
    if (win.size() < 4 || win[1] != 3 || win[2] != 3 || ic[2] - ic[1] != 8) begin
      errors++; $display("FAIL ctr_shape n=%0d hi=%0d gap=%0d exp hi=3 gap=8", win.size(), win[1], ic[2] - ic[1]);
    end
  endtask

  task automatic test_prescaler();
    int win[$]; int ic[$]; int hi;
    hi = 0;
    cycle(1, 0, 8); cycle(1, 1, 3); cycle(1, 2, 2); cycle(1, 0, 9);
    for (int t = 0; t < 50; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL ps_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      hi += int'(pwm_out[0]);
      if (period_irq) begin win.push_back(hi); ic.push_back(t); hi = 0; end
    end
    checks++;
    if (win.size() < 3 || win[1] != 6 || ic[2] - ic[1] != 12) begin
      errors++; $display("FAIL ps_shape n=%0d hi=%0d gap=%0d exp hi=6 gap=12", win.size(), win[1], ic[2] - ic[1]);
    end
  endtask

  task automatic test_shadow();
    int win[$]; int hi; int nirq; int since; bit w; int a; int d; bit done;
    logic [DW-1:0] st;
    hi = 0; nirq = 0; since = 0; done = 0;
    cycle(1, 0, 0); cycle(1, 1, 9); cycle(1, 2, 3); cycle(1, 0, 1);
    for (int t = 0; t < 80; t++) begin
      st = exp_status();
      w = 0; a = 0; d = 0;
      if (nirq == 1 && since == 3) begin w = 1; a = 2; d = 7; end
      if (nirq == 3 && st[CW-1:0] == 8'd9 && !done) begin
        w = 1; a = 2; d = 5; done = 1;
      end
      cycle(w, a, d);
      since++;
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL shd_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      hi += int'(pwm_out[0]);
      if (period_irq) begin win.push_back(hi); hi = 0; nirq++; since = 0; end
    end
    checks++;
    if (win.size() < 6 || win[1] != 3 || win[2] != 7 || win[3] != 7 || win[4] != 7 || win[5] != 5) begin
      errors++; $display("FAIL shd_shape n=%0d hi=%0d,%0d,%0d,%0d,%0d exp 3,7,7,7,5", win.size(), win[1], win[2], win[3], win[4], win[5]);
    end
  endtask

  task automatic test_disable();
    cycle(1, 0, 0); cycle(1, 1, 9); cycle(1, 2, 9); cycle(1, 0, 1);
    for (int t = 0; t < 5; t++) cycle(0, 0, 0);
    cycle(1, 0, 0);
    for (int t = 0; t < 6; t++) begin
      cycle(0, 0, 0);
      checks++;
      if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
        errors++; $display("FAIL dis_cyc t=%0d got %b/%b/%h exp %b/%b/%h", t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
      end
      if (t >= 1) begin
        checks++;
        if (pwm_out !== '0 || rd_data !== '0 || period_irq !== 1'b0) begin
          errors++; $display("FAIL dis_zero t=%0d pwm=%b st=%h irq=%b exp 0", t, pwm_out, rd_data, period_irq);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit found;
    found = 0;
    cycle(1, 0, 0); cycle(1, 1, 9); cycle(1, 2, 3); cycle(1, 0, 1);
    for (int t = 0; t < 30 && !found; t++) begin
      cycle(0, 0, 0);
      if (pwm_out[0] === 1'b1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL mrst_wait pwm0 never high within 30 cycles");
    end
    addr = AW'(0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pwm_out !== '0 || period_irq !== 1'b0 || rd_data !== '0) begin
      errors++; $display("FAIL mrst_out pwm=%b irq=%b ctrl=%h exp 0", pwm_out, period_irq, rd_data);
    end
    addr = AW'(ST);
    model_reset();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_random();
    int ps; int md; int p; int a; bit w; int d;
    for (int r = 0; r < 6; r++) begin
      ps = $urandom_range(0, 2); md = $urandom_range(0, 1); p = $urandom_range(0, 12);
      cycle(1, 0, (md << 1) | (ps << 2));
      cycle(1, 1, p);
      for (int c = 0; c < CH; c++) cycle(1, 2 + c, $urandom_range(0, p + 2));
      cycle(1, 0, 1 | (md << 1) | (ps << 2));
      for (int t = 0; t < 80; t++) begin
        w = 0; a = 0; d = 0;
        if (t == 50) begin w = 1; a = 0; d = (md << 1) | (ps << 2); end
        else if (t == 55) begin w = 1; a = 0; d = 1 | (md << 1) | (ps << 2); end
        else if ($urandom_range(0, 19) == 0) begin
          md = $urandom_range(0, 1); w = 1; a = 0; d = 1 | (md << 1) | (ps << 2);
        end else if ($urandom_range(0, 7) == 0) begin
          w = 1; a = $urandom_range(1, 7); d = $urandom_range(0, 14);
        end
        cycle(w, a, d);
        checks++;
        if ({pwm_out, period_irq, rd_data} !== {e_pwm, e_irq, exp_status()}) begin
          errors++; $display("FAIL rnd_cyc r=%0d t=%0d got %b/%b/%h exp %b/%b/%h", r, t, pwm_out, period_irq, rd_data, e_pwm, e_irq, exp_status());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge_basic();
    test_duty_extremes();
    test_center();
    test_prescaler();
    test_shadow();
    test_disable();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
